// File: rtl/refresh_scheduler.sv
// DRAM refresh scheduler: tracks tREFI obligations, postpones while the bus
// is busy, and issues precharge-all / refresh with tRP and tRFC spacing.
module refresh_scheduler #(
    parameter int T_REFI       = 3900,
    parameter int T_RFC        = 350,
    parameter int T_RP         = 6,
    parameter int MAX_POSTPONE = 8,
    parameter int URGENT_TH    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_idle,
    input  logic       any_bank_open,
    input  logic       ref_ack,
    output logic       ref_hold,
    output logic       pre_all_o,
    output logic       ref_o,
    output logic       ref_busy,
    output logic       urgent_o,
    output logic [3:0] pending_o,
    output logic       err_o
);

    localparam int T_MAX_A = (T_REFI > T_RFC) ? T_REFI : T_RFC;
    localparam int T_MAX   = (T_MAX_A > T_RP) ? T_MAX_A : T_RP;
    localparam int CW      = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam int RP_LOAD  = (T_RP >= 2) ? T_RP - 2 : 0;
    localparam int RFC_LOAD = (T_RFC >= 2) ? T_RFC - 2 : 0;

    localparam logic [CW-1:0] REFI_LAST = CW'(T_REFI - 1);
    localparam logic [3:0]    PEND_MAX  = 4'(MAX_POSTPONE);
    localparam logic [3:0]    PEND_URG  = 4'(URGENT_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] refi_q, refi_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [3:0]    pending_q, pending_d;
    logic          err_q, err_d;
    logic          hold_q, hold_d;
    logic          pre_q, pre_d;
    logic          ref_q, ref_d;
    logic          busy_q, busy_d;

    logic tick;
    logic urgent;
    logic req;

    always_comb begin
        tick   = (refi_q == REFI_LAST);
        refi_d = tick ? '0 : refi_q + 1'b1;
        urgent = (pending_q >= PEND_URG);
        req    = (pending_q != 4'd0) && (bus_idle || urgent);
    end

    // A tick that coincides with a refresh consumes nothing and loses nothing.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (tick && !ref_q) begin
            if (pending_q == PEND_MAX) begin
                err_d = 1'b1;
            end else begin
                pending_d = pending_q + 4'd1;
            end
        end else if (!tick && ref_q) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ref_ack) begin
                    state_d = any_bank_open ? S_PRE : S_REF;
                end
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    timer_d = CW'(RP_LOAD);
                end else begin
                    state_d = S_REF;
                end
            end
            S_WAIT_RP: begin
                if (timer_q == '0) begin
                    state_d = S_REF;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REF: begin
                if (T_RFC > 1) begin
                    state_d = S_WAIT_RFC;
                    timer_d = CW'(RFC_LOAD);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RFC: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state they decode.
    always_comb begin
        hold_d = (state_d != S_IDLE);
        pre_d  = (state_d == S_PRE);
        ref_d  = (state_d == S_REF);
        busy_d = (state_d == S_REF) || (state_d == S_WAIT_RFC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            refi_q    <= '0;
            timer_q   <= '0;
            pending_q <= 4'd0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            pre_q     <= 1'b0;
            ref_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            refi_q    <= refi_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            pre_q     <= pre_d;
            ref_q     <= ref_d;
            busy_q    <= busy_d;
        end
    end

    assign ref_hold  = hold_q;
    assign pre_all_o = pre_q;
    assign ref_o     = ref_q;
    assign ref_busy  = busy_q;
    assign urgent_o  = urgent;
    assign pending_o = pending_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: event-time reference model checked every
// cycle, plus directed scenarios with hand-computed cycle numbers.
module tb_refresh_scheduler;

    localparam int T_REFI       = 20;
    localparam int T_RFC        = 10;
    localparam int T_RP         = 3;
    localparam int MAX_POSTPONE = 4;
    localparam int URGENT_TH    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_idle = 1'b0;
    logic       any_bank_open = 1'b0;
    logic       ref_ack = 1'b0;
    logic       ref_hold;
    logic       pre_all_o;
    logic       ref_o;
    logic       ref_busy;
    logic       urgent_o;
    logic [3:0] pending_o;
    logic       err_o;

    refresh_scheduler #(
        .T_REFI(T_REFI),
        .T_RFC(T_RFC),
        .T_RP(T_RP),
        .MAX_POSTPONE(MAX_POSTPONE),
        .URGENT_TH(URGENT_TH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_idle(bus_idle),
        .any_bank_open(any_bank_open),
        .ref_ack(ref_ack),
        .ref_hold(ref_hold),
        .pre_all_o(pre_all_o),
        .ref_o(ref_o),
        .ref_busy(ref_busy),
        .urgent_o(urgent_o),
        .pending_o(pending_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;
    int pre_seen = 0;
    int ref_seen = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp, tb_cyc);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) tb_cyc = 0;
        else tb_cyc = tb_cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pre_seen = 0;
            ref_seen = 0;
        end else begin
            if (pre_all_o) pre_seen++;
            if (ref_o) ref_seen++;
        end
    end

    // Model: mode 0 released, 1 holding for ack, 2 sequence committed.
    // Once committed, every pulse time follows from the ack cycle.
    int m_cyc = 0;
    int m_pend = 0;
    int m_err = 0;
    int m_mode = 0;
    int m_a = 0;
    int m_pre = 0;

    always @(negedge clk) begin
        int r;
        int e_pre;
        int e_ref;
        int e_busy;
        int tick;
        if (!rst_n) begin
            check("rst_hold", int'(ref_hold), 0);
            check("rst_pre", int'(pre_all_o), 0);
            check("rst_ref", int'(ref_o), 0);
            check("rst_busy", int'(ref_busy), 0);
            check("rst_pending", int'(pending_o), 0);
            check("rst_err", int'(err_o), 0);
            m_cyc = 0;
            m_pend = 0;
            m_err = 0;
            m_mode = 0;
            m_a = 0;
            m_pre = 0;
        end else begin
            r = m_a + 1 + (m_pre != 0 ? T_RP : 0);
            e_pre = (m_mode == 2 && m_pre != 0 && m_cyc == m_a + 1) ? 1 : 0;
            e_ref = (m_mode == 2 && m_cyc == r) ? 1 : 0;
            e_busy = (m_mode == 2 && m_cyc >= r) ? 1 : 0;
            check("m_hold", int'(ref_hold), (m_mode != 0) ? 1 : 0);
            check("m_pre", int'(pre_all_o), e_pre);
            check("m_ref", int'(ref_o), e_ref);
            check("m_busy", int'(ref_busy), e_busy);
            check("m_urgent", int'(urgent_o), (m_pend >= URGENT_TH) ? 1 : 0);
            check("m_pending", int'(pending_o), m_pend);
            check("m_err", int'(err_o), m_err);
            tick = ((m_cyc % T_REFI) == T_REFI - 1) ? 1 : 0;
            case (m_mode)
                0: if (m_pend >= 1 && (bus_idle || m_pend >= URGENT_TH)) m_mode = 1;
                1: if (ref_ack) begin
                    m_mode = 2;
                    m_a = m_cyc;
                    m_pre = any_bank_open ? 1 : 0;
                end
                default: if (m_cyc + 1 == r + T_RFC) m_mode = 0;
            endcase
            if (tick == 1 && e_ref == 0) begin
                if (m_pend == MAX_POSTPONE) m_err = 1;
                else m_pend++;
            end else if (tick == 0 && e_ref == 1) begin
                m_pend--;
            end
            m_cyc++;
        end
    end

    task automatic do_reset(input logic idle, input logic bank, input logic ack);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_idle = idle;
        any_bank_open = bank;
        ref_ack = ack;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to(input int n);
        int guard = 0;
        @(negedge clk);
        while (tb_cyc != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("run_to_timeout", tb_cyc, n);
    endtask

    task automatic find(input int which, input int limit, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (which)
                0: hit = ref_hold;
                1: hit = pre_all_o;
                2: hit = ref_o;
                default: hit = !ref_hold;
            endcase
            if (hit) begin
                at = tb_cyc;
                break;
            end
        end
    endtask

    initial begin
        int t;

        do_reset(1'b1, 1'b1, 1'b1);
        find(0, 60, t);
        check("s1_hold_rise", t, 21);
        find(1, 20, t);
        check("s1_pre", t, 22);
        find(2, 20, t);
        check("s1_ref", t, 25);
        find(3, 30, t);
        check("s1_hold_fall", t, 35);
        check("s1_pending", int'(pending_o), 0);

        do_reset(1'b1, 1'b0, 1'b1);
        find(0, 60, t);
        check("s2_hold_rise", t, 21);
        find(2, 20, t);
        check("s2_ref", t, 22);
        find(3, 30, t);
        check("s2_hold_fall", t, 32);
        #1;
        check("s2_no_pre", pre_seen, 0);

        do_reset(1'b0, 1'b1, 1'b0);
        run_to(50);
        check("s3_pending_50", int'(pending_o), 2);
        check("s3_urgent_50", int'(urgent_o), 0);
        check("s3_hold_50", int'(ref_hold), 0);
        find(0, 40, t);
        check("s3_hold_rise", t, 61);
        check("s3_pending_61", int'(pending_o), 3);
        check("s3_urgent_61", int'(urgent_o), 1);
        @(posedge clk);
        #1;
        ref_ack = 1'b1;
        find(1, 20, t);
        check("s3_pre", t, 63);
        find(2, 20, t);
        check("s3_ref", t, 66);
        find(3, 30, t);
        check("s3_hold_fall", t, 76);
        check("s3_pending_end", int'(pending_o), 2);

        do_reset(1'b0, 1'b1, 1'b0);
        run_to(90);
        check("s4_pending_90", int'(pending_o), 4);
        check("s4_err_90", int'(err_o), 0);
        check("s4_hold_90", int'(ref_hold), 1);
        run_to(99);
        check("s4_err_99", int'(err_o), 0);
        run_to(100);
        check("s4_err_100", int'(err_o), 1);
        run_to(125);
        check("s4_pending_125", int'(pending_o), 4);
        check("s4_err_125", int'(err_o), 1);

        do_reset(1'b1, 1'b1, 1'b0);
        run_to(34);
        @(posedge clk);
        #1;
        ref_ack = 1'b1;
        run_to(39);
        check("s5_ref_39", int'(ref_o), 1);
        check("s5_pending_39", int'(pending_o), 1);
        run_to(40);
        check("s5_pending_40", int'(pending_o), 1);
        check("s5_busy_40", int'(ref_busy), 1);
        run_to(54);
        check("s5_ref_54", int'(ref_o), 1);
        run_to(55);
        check("s5_pending_55", int'(pending_o), 0);
        run_to(60);
        check("s5_pending_60", int'(pending_o), 1);
        check("s5_busy_60", int'(ref_busy), 1);

        do_reset(1'b1, 1'b1, 1'b1);
        run_to(23);
        check("s6_hold_pre_rst", int'(ref_hold), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_hold", int'(ref_hold), 0);
        check("s6_async_busy", int'(ref_busy), 0);
        check("s6_async_pending", int'(pending_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_to(19);
        check("s6_pending_19", int'(pending_o), 0);
        run_to(20);
        check("s6_pending_20", int'(pending_o), 1);
        #1;
        check("s6_no_ref", ref_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
